// File: rtl/seq_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : seq_bit_serializer
//  Description : Parallel-load, MSB-first bit serializer. A pattern is
//                accepted through a valid/ready handshake and shifted out on
//                the single-bit line w, each bit held for DIV clock cycles.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1      rising-edge clock
//    reset       in   1      asynchronous active-high reset
//    load_valid  in   1      load request
//    load_ready  out  1      block can accept a load (IDLE)
//    data        in   WIDTH  pattern, bit WIDTH-1 sent first
//    len         in   LW     bits to send (0 ignored, >WIDTH clamped)
//    abort       in   1      synchronous cancel, priority over load
//    w           out  1      serial output bit
//    bit_strobe  out  1      high in the first cycle of each bit period
//    busy        out  1      transfer in progress
//    done        out  1      one-cycle pulse after a normal completion
// ============================================================================
module seq_bit_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 2,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [LW-1:0]    len,
    input  logic             abort,
    output logic             w,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    // Prescaler needs at least one bit even when DIV is 1.
    localparam int             c_PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(DIV - 1);
    localparam logic [LW-1:0]   c_WIDTH   = LW'(WIDTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [LW-1:0]     cnt_q,   cnt_d;
    logic [c_PW-1:0]   pre_q,   pre_d;
    logic              done_q,  done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            pre_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // abort outranks a simultaneous load; len of zero is a no-op
                if (load_valid && !abort && (len != '0)) begin
                    state_d = S_SHIFT;
                    shreg_d = data;
                    cnt_d   = (len > c_WIDTH) ? c_WIDTH : len;
                    pre_d   = '0;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                end else if (pre_q == c_PRE_MAX) begin
                    pre_d   = '0;
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + c_PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode registered state only; w is gated so that residual
    // pattern bits never leak out while idle.
    assign w          = (state_q == S_SHIFT) & shreg_q[WIDTH-1];
    assign busy       = (state_q == S_SHIFT);
    assign load_ready = (state_q == S_IDLE);
    assign bit_strobe = (state_q == S_SHIFT) && (pre_q == '0);
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_bit_serializer
//  Description : Directed self-checking bench for seq_bit_serializer.
//                Instance A uses DIV=2, instance B uses DIV=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_bit_serializer;

    logic       clk;
    logic       reset;
    logic       lv_a, ab_a, lr_a, w_a, st_a, busy_a, done_a;
    logic [7:0] data_a;
    logic [3:0] len_a;
    logic       lv_b, ab_b, lr_b, w_b, st_b, busy_b, done_b;
    logic [7:0] data_b;
    logic [3:0] len_b;

    int n_checks = 0;
    int n_fail   = 0;

    seq_bit_serializer #(.WIDTH(8), .DIV(2)) u_dut_a (
        .clk(clk), .reset(reset), .load_valid(lv_a), .load_ready(lr_a),
        .data(data_a), .len(len_a), .abort(ab_a), .w(w_a),
        .bit_strobe(st_a), .busy(busy_a), .done(done_a)
    );

    seq_bit_serializer #(.WIDTH(8), .DIV(1)) u_dut_b (
        .clk(clk), .reset(reset), .load_valid(lv_b), .load_ready(lr_b),
        .data(data_b), .len(len_b), .abort(ab_b), .w(w_b),
        .bit_strobe(st_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_w"},     32'(w_a),    32'd0);
        chk({tag, "_busy"},  32'(busy_a), 32'd0);
        chk({tag, "_ready"}, 32'(lr_a),   32'd1);
        chk({tag, "_done"},  32'(done_a), 32'd0);
        chk({tag, "_strb"},  32'(st_a),   32'd0);
    endtask

    // Load on instance A, then check every cycle from E0 to E(2n+1).
    // bits holds the expected serial stream MSB-first.
    task automatic run_a(input logic [7:0] d, input logic [3:0] l,
                         input logic [7:0] bits, input int n, input string tag);
        logic eb, ew;
        @(negedge clk);
        lv_a = 1'b1; data_a = d; len_a = l;
        @(posedge clk); #1;
        lv_a = 1'b0;
        for (int c = 0; c <= 2 * n + 1; c++) begin
            eb = (c < 2 * n);
            ew = eb ? bits[7 - c / 2] : 1'b0;
            chk({tag, "_w"},     32'(w_a),    32'(ew));
            chk({tag, "_busy"},  32'(busy_a), 32'(eb));
            chk({tag, "_ready"}, 32'(lr_a),   32'(!eb));
            chk({tag, "_strb"},  32'(st_a),   32'(eb && (c % 2 == 0)));
            chk({tag, "_done"},  32'(done_a), 32'(c == 2 * n));
            @(posedge clk); #1;
        end
    endtask

    logic [17:0] exp_w_b, exp_busy_b, exp_done_b;

    initial begin
        reset = 1'b0;
        lv_a = 1'b0; ab_a = 1'b0; data_a = '0; len_a = '0;
        lv_b = 1'b0; ab_b = 1'b0; data_b = '0; len_b = '0;

        // asynchronous reset between edges
        #2 reset = 1'b1;
        #1 chk_idle_a("reset");
        chk("reset_b_busy", 32'(busy_b), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_a("reset_hold");

        // full pattern, short pattern, clamped length
        run_a(8'b1011_0101, 4'd8,  8'b1011_0101, 8, "full");
        run_a(8'hB0,        4'd4,  8'b1011_0000, 4, "short");

        // len=0 is ignored
        @(negedge clk);
        lv_a = 1'b1; data_a = 8'hFF; len_a = 4'd0;
        @(posedge clk); #1;
        lv_a = 1'b0;
        chk_idle_a("len0");
        @(posedge clk); #1;
        chk_idle_a("len0_hold");

        run_a(8'hA5, 4'd15, 8'hA5, 8, "clamp");

        // abort during bit 3 (driven from E6 to E8)
        @(negedge clk);
        lv_a = 1'b1; data_a = 8'hFF; len_a = 4'd8;
        @(posedge clk); #1;
        lv_a = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("abort_pre_busy", 32'(busy_a), 32'd1);
        chk("abort_pre_w",    32'(w_a),    32'd1);
        ab_a = 1'b1;
        @(posedge clk); #1;
        chk_idle_a("abort");
        // load attempt while abort still high in IDLE
        lv_a = 1'b1;
        @(posedge clk); #1;
        chk_idle_a("abort_load");
        ab_a = 1'b0; lv_a = 1'b0;
        @(posedge clk); #1;
        chk_idle_a("abort_after");

        // reset during bit 5 (E10..E12)
        @(negedge clk);
        lv_a = 1'b1; data_a = 8'hAA; len_a = 4'd8;
        @(posedge clk); #1;
        lv_a = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("rstmid_pre_busy", 32'(busy_a), 32'd1);
        #2 reset = 1'b1;
        #1 chk_idle_a("rstmid");
        #1 reset = 1'b0;
        run_a(8'hFF, 4'd8, 8'hFF, 8, "rst_reload");

        // back-to-back on the DIV=1 instance, reload during done
        exp_w_b    = 18'b11011010_0_11010000_0;
        exp_busy_b = 18'b11111111_0_11111111_0;
        exp_done_b = 18'b00000000_1_00000000_1;
        @(negedge clk);
        lv_b = 1'b1; data_b = 8'hDA; len_b = 4'd8;
        @(posedge clk); #1;
        lv_b = 1'b0;
        for (int c = 0; c < 18; c++) begin
            chk("b2b_w",     32'(w_b),    32'(exp_w_b[17 - c]));
            chk("b2b_busy",  32'(busy_b), 32'(exp_busy_b[17 - c]));
            chk("b2b_strb",  32'(st_b),   32'(exp_busy_b[17 - c]));
            chk("b2b_ready", 32'(lr_b),   32'(!exp_busy_b[17 - c]));
            chk("b2b_done",  32'(done_b), 32'(exp_done_b[17 - c]));
            if (c == 8) begin
                lv_b = 1'b1; data_b = 8'hD0; len_b = 4'd8;
            end else begin
                lv_b = 1'b0;
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
